bank_port_arbiter: RTL and testbench
====================================

Name: bank_port_arbiter

Overview:
- Round-robin arbiter that shares the single feature/weight memory bank request port among up to NUM_REQ requesters (decoder, replay controller, writeback units).
- Requesters raise req and wait for a one-cycle grant pulse, then present one packet in the grant cycle.
- The arbiter forwards that packet to the bank and holds bank_busy high until the bank signals mem_done.
- Sits between the decoder/RS front end and the memory controller; its grant and bank_busy outputs feed the decoder's grant and bank_busy inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PKT_W, 16, request packet width in bits
TIMEOUT, 255, max BUSY cycles before forced release (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
req  input  NUM_REQ  level request per requester, held until granted
pkt_valid_in  input  NUM_REQ  requester i drives its packet this cycle
pkt_in  input  NUM_REQ*PKT_W  packet bus; slice i = bits [i*PKT_W +: PKT_W]
mem_done  input  1  bank finished current access (one-cycle pulse)
grant  output  NUM_REQ  one-hot, one-cycle grant pulse (registered)
grant_id  output  $clog2(NUM_REQ)  index of the last winner
mem_pkt_valid  output  1  one-cycle packet strobe to the bank (registered)
mem_pkt  output  PKT_W  packet to the bank; holds its value between strobes
bank_busy  output  1  bank owned; high whenever state != IDLE
proto_err  output  1  sticky: granted requester did not drive pkt_valid_in
grant_cnt  output  16  total grants issued, saturating at 16'hFFFF

Behaviour:
- Reset: state=IDLE; grant=0, grant_id=0, mem_pkt_valid=0, mem_pkt=0, bank_busy=0, proto_err=0, grant_cnt=0; round-robin pointer ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation discards the in-flight grant; no mem_pkt_valid is issued afterwards.
- States: IDLE, GRANT, BUSY. All outputs are registered.
- IDLE: if |req, pick the winner as the first set req index searching from (ptr+1) mod NUM_REQ upward, with wrap-around.
  - Next cycle: grant[w]=1, grant_id=w, ptr=w, grant_cnt++ (saturating), state=GRANT.
  - If no req, stay in IDLE.
- GRANT (exactly 1 cycle): grant is cleared next cycle.
  - If pkt_valid_in[grant_id]=1: next cycle mem_pkt=pkt_in slice grant_id, mem_pkt_valid=1 for 1 cycle, state=BUSY.
  - Otherwise: proto_err=1 (sticky until reset), no strobe, state=IDLE; ptr still advances.
  - pkt_valid_in from non-granted requesters is ignored.
- BUSY: mem_done=1 -> state=IDLE next cycle. Otherwise remain in BUSY.
- mem_done in IDLE or GRANT is ignored. mem_done coinciding with the mem_pkt_valid cycle counts as completion.
- Latency: req seen in IDLE at cycle t -> grant at t+1 -> mem_pkt_valid at t+2 -> bank_busy high from t+1. mem_done at cycle d -> bank_busy low at d+1. Earliest next grant is d+2.
- Fairness: with all req held high, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ grant slots.
- A requester that drops req before being granted is simply skipped. A grant is never issued to a requester whose req is low in the IDLE sampling cycle.
- grant is always one-hot or zero; at most one grant per arbitration round.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit busy counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without mem_done, force state=IDLE next cycle and set output timeout_err (1 bit, sticky, reset 0).
  - Port timeout_err exists only when the macro is defined.
- Undefined: no counter, no timeout_err port; BUSY waits indefinitely for mem_done.

Test Plan:
- Reset then req=4'b0001 at cycle 0, pkt_valid_in[0]=1 with pkt 16'hA5A5 in the grant cycle -> grant=4'b0001 at cycle 1, mem_pkt_valid=1 with mem_pkt=16'hA5A5 at cycle 2, bank_busy 1 until the cycle after mem_done.
- req=4'b1111 held for 5 rounds, mem_done 3 cycles after each strobe -> grant_id sequence 0,1,2,3,0; grant_cnt=5.
- req=4'b0100 granted but pkt_valid_in held at 0 -> no mem_pkt_valid, proto_err=1, back in IDLE the next cycle; next req=4'b0110 grants requester 1 after the wrap from ptr=2... check: search starts at 3, wraps to 1 -> grant_id=1.
- mem_done pulsed while in IDLE, then req=4'b0010 -> mem_done ignored, normal grant; BUSY holds until a new mem_done.
- Reset asserted during BUSY -> next cycle all outputs at reset values; subsequent req=4'b1000 -> first priority search starts at 0, grant_id=3.
- With ARB_TIMEOUT_EN and TIMEOUT=10, no mem_done -> bank_busy drops 10 BUSY cycles after entry, timeout_err=1; the next pending req is then granted.

Source files
------------

// File: rtl/bank_port_arbiter.sv
// bank_port_arbiter: round-robin owner of the shared memory bank request port.
// Define ARB_TIMEOUT_EN to force release of a BUSY bank after TIMEOUT cycles.
module bank_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PKT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            pkt_valid_in,
    input  logic [NUM_REQ*PKT_W-1:0]      pkt_in,
    input  logic                          mem_done,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          mem_pkt_valid,
    output logic [PKT_W-1:0]              mem_pkt,
    output logic                          bank_busy,
    output logic                          proto_err,
    output logic [15:0]                   grant_cnt
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          found;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]    busy_cnt;
`endif

    // First requester above the last winner, wrapping around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= IW'(NUM_REQ - 1);
            grant         <= '0;
            grant_id      <= '0;
            mem_pkt_valid <= 1'b0;
            mem_pkt       <= '0;
            bank_busy     <= 1'b0;
            proto_err     <= 1'b0;
            grant_cnt     <= '0;
`ifdef ARB_TIMEOUT_EN
            busy_cnt      <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            grant         <= '0;
            mem_pkt_valid <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    grant     <= NUM_REQ'(1) << win;
                    grant_id  <= win;
                    ptr       <= win;
                    grant_cnt <= (grant_cnt == 16'hFFFF) ? grant_cnt : grant_cnt + 16'd1;
                    bank_busy <= 1'b1;
                    state     <= GRANT;
                end
                GRANT: if (pkt_valid_in[grant_id]) begin
                    mem_pkt       <= pkt_in[int'(grant_id)*PKT_W +: PKT_W];
                    mem_pkt_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    busy_cnt      <= '0;
`endif
                    state         <= BUSY;
                end else begin
                    proto_err <= 1'b1;
                    bank_busy <= 1'b0;
                    state     <= IDLE;
                end
                BUSY: if (mem_done) begin
                    bank_busy <= 1'b0;
                    state     <= IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (busy_cnt == 8'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    bank_busy   <= 1'b0;
                    state       <= IDLE;
                end else begin
                    busy_cnt <= busy_cnt + 8'd1;
`endif
                end
                default: begin
                    bank_busy <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bank_port_arbiter.sv
// tb_bank_port_arbiter: directed vector table, fairness rounds and randomized
// transactions against a round-robin reference model.
module tb_bank_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, pkt_valid_in, grant;
    logic [63:0] pkt_in;
    logic        mem_done;
    logic [1:0]  grant_id;
    logic        mem_pkt_valid, bank_busy, proto_err;
    logic [15:0] mem_pkt, grant_cnt;
`ifdef ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bank_port_arbiter #(.NUM_REQ(4), .PKT_W(16), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .req(req), .pkt_valid_in(pkt_valid_in),
        .pkt_in(pkt_in), .mem_done(mem_done), .grant(grant), .grant_id(grant_id),
        .mem_pkt_valid(mem_pkt_valid), .mem_pkt(mem_pkt), .bank_busy(bank_busy),
        .proto_err(proto_err), .grant_cnt(grant_cnt)
`ifdef ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req, pv;
        logic [63:0] pkt;
        logic        done;
        logic [3:0]  g;
        logic [1:0]  gid;
        logic        mv;
        logic [15:0] mp;
        logic        busy, perr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] pv,
                       input logic [63:0] pkt, input logic done, input logic [3:0] g,
                       input logic [1:0] gid, input logic mv, input logic [15:0] mp,
                       input logic busy, input logic perr, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.req = rq; v.pv = pv; v.pkt = pkt; v.done = done;
        v.g = g; v.gid = gid; v.mv = mv; v.mp = mp; v.busy = busy; v.perr = perr; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_winner(input int last, input logic [3:0] m);
        for (int k = 1; k <= 4; k++)
            if (m[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    initial begin
        int          mptr, w, d;
        logic        perr_m, ok;
        logic [15:0] cnt_m, mp_m;
        logic [63:0] pk;

        reset = 1'b1; req = '0; pkt_valid_in = '0; pkt_in = '0; mem_done = 1'b0;

        add(1, 4'b0000, 4'b0000, 64'h0, 0, 4'b0000, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 4'b0001, 4'b0000, 64'h0, 0, 4'b0001, 0, 0, 16'h0000, 1, 0, 1);
        add(0, 4'b0000, 4'b0001, 64'h0000_0000_0000_A5A5, 0, 4'b0000, 0, 1, 16'hA5A5, 1, 0, 1);
        add(0, 4'b0000, 4'b0000, 64'h0, 0, 4'b0000, 0, 0, 16'hA5A5, 1, 0, 1);
        add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 16'hA5A5, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 64'h0, 0, 4'b0000, 0, 0, 16'hA5A5, 0, 0, 1);
        add(0, 4'b0100, 4'b0000, 64'h0, 0, 4'b0100, 2, 0, 16'hA5A5, 1, 0, 2);
        add(0, 4'b0000, 4'b0001, 64'h0000_0000_0000_1234, 0, 4'b0000, 2, 0, 16'hA5A5, 0, 1, 2);
        add(0, 4'b0110, 4'b0000, 64'h0, 0, 4'b0010, 1, 0, 16'hA5A5, 1, 1, 3);
        add(0, 4'b0000, 4'b0010, 64'h0000_0000_BEEF_0000, 0, 4'b0000, 1, 1, 16'hBEEF, 1, 1, 3);
        add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 1, 0, 16'hBEEF, 0, 1, 3);
        add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 1, 0, 16'hBEEF, 0, 1, 3);
        add(0, 4'b0010, 4'b0000, 64'h0, 0, 4'b0010, 1, 0, 16'hBEEF, 1, 1, 4);
        add(0, 4'b0000, 4'b0010, 64'h0000_0000_C3C3_0000, 1, 4'b0000, 1, 1, 16'hC3C3, 1, 1, 4);
        add(0, 4'b0000, 4'b0000, 64'h0, 0, 4'b0000, 1, 0, 16'hC3C3, 1, 1, 4);
        add(0, 4'b0000, 4'b0000, 64'h0, 0, 4'b0000, 1, 0, 16'hC3C3, 1, 1, 4);
        add(1, 4'b0000, 4'b0000, 64'h0, 0, 4'b0000, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 4'b1000, 4'b0000, 64'h0, 0, 4'b1000, 3, 0, 16'h0000, 1, 0, 1);
        add(0, 4'b0000, 4'b1000, 64'h7E7E_0000_0000_0000, 1, 4'b0000, 3, 1, 16'h7E7E, 1, 0, 1);
        add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 3, 0, 16'h7E7E, 0, 0, 1);
        add(0, 4'b0001, 4'b0000, 64'h0, 0, 4'b0001, 0, 0, 16'h7E7E, 1, 0, 2);
        add(1, 4'b0000, 4'b0001, 64'h0000_0000_0000_5555, 0, 4'b0000, 0, 0, 16'h0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0001, 64'h0000_0000_0000_5555, 0, 4'b0000, 0, 0, 16'h0000, 0, 0, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; req = vecs[i].req; pkt_valid_in = vecs[i].pv;
            pkt_in = vecs[i].pkt; mem_done = vecs[i].done;
            tick();
            chk($sformatf("v%0d.grant", i), 64'(grant), 64'(vecs[i].g));
            chk($sformatf("v%0d.grant_id", i), 64'(grant_id), 64'(vecs[i].gid));
            chk($sformatf("v%0d.mem_pkt_valid", i), 64'(mem_pkt_valid), 64'(vecs[i].mv));
            chk($sformatf("v%0d.mem_pkt", i), 64'(mem_pkt), 64'(vecs[i].mp));
            chk($sformatf("v%0d.bank_busy", i), 64'(bank_busy), 64'(vecs[i].busy));
            chk($sformatf("v%0d.proto_err", i), 64'(proto_err), 64'(vecs[i].perr));
            chk($sformatf("v%0d.grant_cnt", i), 64'(grant_cnt), 64'(vecs[i].cnt));
        end

        // All requesters held high: grants must rotate 0,1,2,3,0.
        reset = 1'b0; pkt_valid_in = '0; mem_done = 1'b0; req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            tick();
            chk($sformatf("rr%0d.grant_id", r), 64'(grant_id), 64'(r % 4));
            chk($sformatf("rr%0d.grant", r), 64'(grant), 64'(4'b0001 << (r % 4)));
            pkt_valid_in = 4'b1111;
            pk = 64'h0;
            for (int s = 0; s < 4; s++) pk[s*16 +: 16] = 16'(16'h1000 * (s + 1) + r);
            pkt_in = pk;
            tick();
            pkt_valid_in = '0;
            chk($sformatf("rr%0d.mem_pkt", r), 64'(mem_pkt), 64'(16'h1000 * ((r % 4) + 1) + r));
            tick();
            tick();
            mem_done = 1'b1;
            tick();
            mem_done = 1'b0;
            chk($sformatf("rr%0d.busy_low", r), 64'(bank_busy), 64'(0));
        end
        chk("rr.grant_cnt", 64'(grant_cnt), 64'(5));

        // Randomized transactions against the round-robin model.
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0;
        mptr = 3; perr_m = 1'b0; cnt_m = 16'h0; mp_m = 16'h0;
        for (int n = 0; n < 200; n++) begin
            req = 4'($urandom); pkt_valid_in = 4'($urandom); mem_done = 1'($urandom);
            pkt_in = {$urandom, $urandom};
            tick();
            if (req == 4'b0000) begin
                chk("rnd.idle_grant", 64'(grant), 64'(0));
                chk("rnd.idle_busy", 64'(bank_busy), 64'(0));
                continue;
            end
            w = rr_winner(mptr, req);
            mptr = w;
            cnt_m++;
            chk("rnd.grant", 64'(grant), 64'(4'b0001 << w));
            chk("rnd.grant_id", 64'(grant_id), 64'(w));
            chk("rnd.busy_grant", 64'(bank_busy), 64'(1));
            chk("rnd.grant_cnt", 64'(grant_cnt), 64'(cnt_m));
            chk("rnd.proto_err_hold", 64'(proto_err), 64'(perr_m));
            ok = ($urandom_range(0, 3) != 0);
            pk = {$urandom, $urandom};
            pkt_valid_in = 4'($urandom);
            pkt_valid_in[w] = ok;
            pkt_in = pk;
            req = 4'($urandom); mem_done = 1'($urandom);
            tick();
            chk("rnd.grant_clear", 64'(grant), 64'(0));
            chk("rnd.mem_pkt_valid", 64'(mem_pkt_valid), 64'(ok));
            if (ok) mp_m = pk[w*16 +: 16];
            else perr_m = 1'b1;
            chk("rnd.mem_pkt", 64'(mem_pkt), 64'(mp_m));
            chk("rnd.proto_err", 64'(proto_err), 64'(perr_m));
            chk("rnd.busy_after_grant", 64'(bank_busy), 64'(ok));
            if (!ok) continue;
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                mem_done = 1'b0; req = 4'($urandom); pkt_valid_in = 4'($urandom);
                tick();
                chk("rnd.busy_hold", 64'(bank_busy), 64'(1));
                chk("rnd.no_strobe", 64'(mem_pkt_valid), 64'(0));
                chk("rnd.no_grant_busy", 64'(grant), 64'(0));
            end
            mem_done = 1'b1; req = 4'($urandom);
            tick();
            mem_done = 1'b0;
            chk("rnd.busy_release", 64'(bank_busy), 64'(0));
            chk("rnd.no_grant_release", 64'(grant), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
